prio_encoder_rr: RTL and testbench

Parametrised, registered N-to-log2(N) priority encoder. Successor to the combinational 8-to-3 octal encoder.
- Adds selectable fixed-priority or round-robin arbitration.
- Adds a valid/ready handshake on input and output, with one output register stage.
- Adds multi-hot and all-zero detection, plus a saturating multi-hot event counter.
- Sits between request sources (interrupt lines, channel requests) and a consumer that needs a binary index.

---
 rtl/prio_encoder_rr_pkg.sv | 15 +
 rtl/prio_encoder_rr_pick.sv | 49 ++++
 rtl/prio_encoder_rr.sv | 92 +++++++++
 tb/tb_prio_encoder_rr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_encoder_rr_pkg.sv
// Shared types for the registered priority encoder: arbitration mode and
// output-stage state encoding.
package prio_enc_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        EMPTY,
        FULL
    } out_state_e;

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// Combinational winner picker: rotates the request vector so the search
// start sits at bit 0, picks, then maps the position back to an absolute index.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  mode_e        mode,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         found
);

    logic [W-1:0] shift;
    logic [N-1:0] rot;
    int           pos;
    int           abs_pos;

    always_comb begin
        shift = (mode == MODE_RR) ? start : '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[(i + int'(shift)) % N];
        end

        // Round-robin takes the first set bit at or after start; fixed
        // priority takes the highest set bit of the unrotated vector.
        pos = 0;
        if (mode == MODE_RR) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (rot[i]) pos = i;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rot[i]) pos = i;
            end
        end

        abs_pos = pos + int'(shift);
        if (abs_pos >= N) abs_pos = abs_pos - N;

        found  = |req;
        idx    = found ? W'(abs_pos) : '0;
        onehot = found ? (N'(1) << abs_pos) : '0;
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed/round-robin arbitration,
// valid/ready handshakes, multi-hot / all-zero flags and a saturating counter.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8,
    localparam int W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_i,
    input  logic [N-1:0]     req_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [W-1:0]     idx_o,
    output logic [N-1:0]     onehot_o,
    output logic             multi_o,
    output logic             zero_o,
    output logic [CNT_W-1:0] multi_cnt_o,
    output logic             state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; the output stage accepts whenever it is empty or being drained.

    localparam logic [W-1:0]     PTR_LAST = W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    out_state_e   state;
    out_state_e   state_nxt;
    logic [W-1:0] ptr;
    logic [W-1:0] start;
    mode_e        mode;
    logic         accept;
    logic         multi_in;
    logic [W-1:0] pick_idx;
    logic [N-1:0] pick_onehot;
    logic         pick_found;

    assign mode     = mode_e'(mode_i);
    assign start    = (ptr == PTR_LAST) ? '0 : ptr + W'(1);
    assign multi_in = (req_i & (req_i - N'(1))) != '0;
    assign valid_o  = (state == FULL);
    assign state_o  = state;

    prio_pick #(.N(N)) u_pick (
        .req    (req_i),
        .start  (start),
        .mode   (mode),
        .idx    (pick_idx),
        .onehot (pick_onehot),
        .found  (pick_found)
    );

    always_comb begin
        req_ready_o = (state == EMPTY) || ready_i;
        accept      = req_valid_i && req_ready_o;
        state_nxt   = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (ready_i && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            ptr         <= PTR_LAST;
            idx_o       <= '0;
            onehot_o    <= '0;
            multi_o     <= 1'b0;
            zero_o      <= 1'b0;
            multi_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_o    <= pick_idx;
                onehot_o <= pick_onehot;
                multi_o  <= multi_in;
                zero_o   <= !pick_found;
                // Pointer only advances on real round-robin grants.
                if (mode == MODE_RR && pick_found) ptr <= pick_idx;
                if (multi_in && multi_cnt_o != CNT_MAX) multi_cnt_o <= multi_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: directed scenarios plus random traffic, checked
// by a queue-based scoreboard fed from an arbitration reference model.
module tb_prio_encoder_rr;

    localparam int N     = 8;
    localparam int W     = 3;
    localparam int CNT_W = 4;
    localparam int EXP_W = W + N + 2 + CNT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode_i = 1'b0;
    logic [N-1:0]     req_i = '0;
    logic             req_valid_i = 1'b0;
    logic             ready_i = 1'b1;
    logic             req_ready_o;
    logic             valid_o;
    logic [W-1:0]     idx_o;
    logic [N-1:0]     onehot_o;
    logic             multi_o;
    logic             zero_o;
    logic [CNT_W-1:0] multi_cnt_o;
    logic             state_o;

    prio_encoder_rr #(.N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_i      (mode_i),
        .req_i       (req_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .idx_o       (idx_o),
        .onehot_o    (onehot_o),
        .multi_o     (multi_o),
        .zero_o      (zero_o),
        .multi_cnt_o (multi_cnt_o),
        .state_o     (state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    int m_ptr = N - 1;
    int m_cnt = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference arbitration: returns winning index, or -1 for an empty vector.
    function automatic int ref_pick(input logic [N-1:0] r, input logic m, input int p);
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Scoreboard monitor: samples on the falling edge, pops on output
    // transfers, pushes model results on input transfers.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        logic [N-1:0]     oh;
        int               w;
        int               ones;
        bit               exp_ready;
        if (!rst_n) begin
            exp_q.delete();
            m_ptr = N - 1;
            m_cnt = 0;
        end else begin
            exp_ready = (exp_q.size() == 0) || ready_i;
            check("valid_o", int'(valid_o), int'(exp_q.size() != 0));
            check("state_o", int'(state_o), int'(exp_q.size() != 0));
            check("req_ready_o", int'(req_ready_o), int'(exp_ready));
            if (exp_q.size() != 0 && ready_i) begin
                e = exp_q.pop_front();
                check("idx_o", int'(idx_o), int'(e[EXP_W-1 -: W]));
                check("onehot_o", int'(onehot_o), int'(e[EXP_W-W-1 -: N]));
                check("multi_o", int'(multi_o), int'(e[CNT_W+1]));
                check("zero_o", int'(zero_o), int'(e[CNT_W]));
                check("multi_cnt_o", int'(multi_cnt_o), int'(e[CNT_W-1:0]));
            end
            if (req_valid_i && exp_ready) begin
                w = ref_pick(req_i, mode_i, m_ptr);
                oh = (w >= 0) ? (N'(1) << w) : '0;
                ones = $countones(req_i);
                if (ones > 1 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (mode_i && w >= 0) m_ptr = w;
                exp_q.push_back({W'((w >= 0) ? w : 0), oh, (ones > 1), (w < 0), CNT_W'(m_cnt)});
            end
        end
    end

    // Driver tasks
    task automatic step(input logic v, input logic [N-1:0] r, input logic m, input logic rdy);
        req_valid_i = v;
        req_i       = r;
        mode_i      = m;
        ready_i     = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        ready_i     = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b1);
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [EXP_W-1:0] held;

        do_reset();
        @(negedge clk);
        check("rst_valid_o", int'(valid_o), 0);
        check("rst_idx_o", int'(idx_o), 0);
        check("rst_onehot_o", int'(onehot_o), 0);
        check("rst_multi_o", int'(multi_o), 0);
        check("rst_zero_o", int'(zero_o), 0);
        check("rst_multi_cnt_o", int'(multi_cnt_o), 0);
        check("rst_req_ready_o", int'(req_ready_o), 1);
        @(posedge clk);
        #1;

        // Walking one and multi-hot, fixed priority
        for (int i = 0; i < N; i++) step(1'b1, N'(1) << i, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b1, 8'h06, 1'b0, 1'b1);
        drain();
        check("fixed_cnt_end", int'(multi_cnt_o), 2);

        // Round-robin sweep from reset
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 8'hFF, 1'b1, 1'b1);
        step(1'b1, 8'h21, 1'b1, 1'b1);
        drain();

        // Backpressure: hold, then stream with no bubble
        step(1'b1, N'($urandom), 1'(($urandom_range(0, 1))), 1'b0);
        req_i = N'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            held = exp_q[0];
            check("bp_req_ready_o", int'(req_ready_o), 0);
            check("bp_idx_hold", int'(idx_o), int'(held[EXP_W-1 -: W]));
            check("bp_onehot_hold", int'(onehot_o), int'(held[EXP_W-W-1 -: N]));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1'b1;
            ready_i     = 1'b1;
            req_i       = N'($urandom);
            mode_i      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stream_valid_o", int'(valid_o), 1);
            @(posedge clk);
            #1;
        end
        drain();

        // Zero vector in round-robin leaves the pointer alone
        do_reset();
        step(1'b1, 8'h08, 1'b1, 1'b1);
        step(1'b1, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0) ? '0 : N'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Counter saturation, then reset while a result is held
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'hFF, 1'b0, 1'b1);
        drain();
        check("sat_cnt", int'(multi_cnt_o), 15);
        step(1'b1, 8'h18, 1'b0, 1'b0);
        req_valid_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid_o", int'(valid_o), 0);
        check("mid_rst_cnt", int'(multi_cnt_o), 0);
        @(posedge clk);
        #1;
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
